// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam bit          PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    // Returns 1 when data plus received parity bit do not match the configured parity.
    function automatic logic even_par_err(input logic [DATA_BITS-1:0] data, input logic p);
        return (^{data, p}) ^ !PARITY_EVEN;
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial input and byte-level output bundle of the UART frame receiver.
interface uart_rx_frame_if;
    import uart_rx_pkg::*;

    logic                 ser_in;
    logic [DATA_BITS-1:0] par_out;
    logic                 Rx_valid;
    logic                 err_par;
    logic                 err_stop;

    // master: line driver / byte consumer; slave: the receiver itself
    modport master (
        output ser_in,
        input  par_out,
        input  Rx_valid,
        input  err_par,
        input  err_stop
    );

    modport slave (
        input  ser_in,
        output par_out,
        output Rx_valid,
        output err_par,
        output err_stop
    );

endinterface

// File: rtl/uart_rx_baud_tick.sv
// Bit-period cycle counter: emits a 1-cycle tick at mid-start (half_i) or at each full bit period.
module uart_rx_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 15259
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = clear_i ? '0 : cnt_q + CntW'(1);
        tick_o = half_i ? (cnt_q == HalfCnt) : (cnt_q == FullCnt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, idle-high line.
// Define UART_RX_SYNC_EN to pass ser_in through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 15259,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic            ref_clk,
    input  logic            reset,
    uart_rx_frame_if.slave  bus
);
    import uart_rx_pkg::*;

    localparam int unsigned BitW = $clog2(DATA_BITS);

    logic line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.ser_in};
        end
    end

    assign line = sync_q[1];
`else
    assign line = bus.ser_in;
`endif

    rx_state_t            state_q, state_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] par_out_q, par_out_d;
    logic                 p_err_q, p_err_d;
    logic                 err_par_q, err_par_d;
    logic                 err_stop_q, err_stop_d;
    logic                 valid_q, valid_d;
    logic                 tick, clear, half;

    uart_rx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (ref_clk),
        .rst_i   (reset),
        .clear_i (clear),
        .half_i  (half),
        .tick_o  (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_out_d  = par_out_q;
        p_err_d    = p_err_q;
        err_par_d  = err_par_q;
        err_stop_d = err_stop_q;
        valid_d    = 1'b0;
        clear      = 1'b0;
        half       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!line) begin
                    clear   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                half = 1'b1;
                if (tick) begin
                    if (!line) begin
                        clear     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;  // glitch: outputs untouched
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    clear   = 1'b1;
                    shreg_d = {line, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    clear   = 1'b1;
                    p_err_d = even_par_err(shreg_q, line);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    clear      = 1'b1;
                    par_out_d  = shreg_q;
                    err_par_d  = p_err_q;
                    err_stop_d = ~line;
                    valid_d    = 1'b1;
                    // A low stop bit must not be mistaken for the next start bit.
                    state_d    = line ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_out_q  <= '0;
            p_err_q    <= 1'b0;
            err_par_q  <= 1'b0;
            err_stop_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_out_q  <= par_out_d;
            p_err_q    <= p_err_d;
            err_par_q  <= err_par_d;
            err_stop_q <= err_stop_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.par_out  = par_out_q;
    assign bus.Rx_valid = valid_q;
    assign bus.err_par  = err_par_q;
    assign bus.err_stop = err_stop_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at 16 clocks per bit.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

    localparam int unsigned C = 16;
    localparam int unsigned H = C / 2;
`ifdef UART_RX_SYNC_EN
    localparam int unsigned SyncLat = 2;
`else
    localparam int unsigned SyncLat = 0;
`endif
    // From the cycle the start bit is driven to the cycle Rx_valid is high.
    localparam int unsigned Lat = 1 + H + 10 * C + 1 + SyncLat;

    typedef struct {
        logic [7:0]  data;
        logic        ep;
        logic        es;
        int unsigned t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          vcount = 0;
    int          npush = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_if bus();

    uart_rx_frame #(
        .CLKS_PER_BIT (C)
    ) dut (
        .ref_clk (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.Rx_valid === 1'b1) begin
            vcount++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("par_out", {24'd0, bus.par_out}, {24'd0, e.data});
                check("err_par", {31'd0, bus.err_par}, {31'd0, e.ep});
                check("err_stop", {31'd0, bus.err_stop}, {31'd0, e.es});
                check("latency", cyc, e.t);
            end
        end else if (sb.size() > 0 && cyc > sb[0].t + 4) begin
            check("missing_valid", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
    end

    task automatic drive_bit(input logic b);
        bus.ser_in = b;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input bit idle);
        logic [11:0] w;
        exp_t        e;
        w = {1'b1, 1'b0, d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7], par, stop};
        for (int i = (idle ? 11 : 10); i >= 0; i--) begin
            if (i == 10) begin
                e.data = d;
                e.ep   = ^{d, par};
                e.es   = ~stop;
                e.t    = cyc + Lat;
                sb.push_back(e);
                npush++;
            end
            drive_bit(w[i]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_par_out"}, {24'd0, bus.par_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.Rx_valid}, 32'd0);
        check({tag, "_err_par"}, {31'd0, bus.err_par}, 32'd0);
        check({tag, "_err_stop"}, {31'd0, bus.err_stop}, 32'd0);
        check({tag, "_state"}, {29'd0, dut.state_q}, {29'd0, IDLE});
    endtask

    initial begin
        bus.ser_in = 1'b1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Clean frame, then a parity error.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);

        // Stop bit low, line held low (break), then recovery frame.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        repeat (12) drive_bit(1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);

        // Short low glitch on an idle line.
        drive_bit(1'b1);
        bus.ser_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.ser_in = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        repeat (200) @(posedge clk);
        #1;

        // Back-to-back frames.
        send_frame(8'h00, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0);
        repeat (2) drive_bit(1'b1);

        // Reset in the middle of the data bits; the partial frame must vanish.
        bus.ser_in = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        bus.ser_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        rst = 1'b0;
        drive_bit(1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);

        repeat (300) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        check("valid_count", vcount, npush);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
